fir_decim_avg: RTL and testbench

Downstream stage of the 5-tap FIR datapath. Consumes the FIR's signed 8-bit `result` stream, averages each non-overlapping block of 2^LOG2_DECIM accepted samples (accumulate-and-dump), and buffers the decimated values in a small FIFO. The FIFO drains through a valid/ready interface to the next consumer. Overruns are flagged with a sticky status bit.

---
 rtl/fir_decim_avg.sv | 149 ++++++++++++++
 tb/tb_fir_decim_avg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_avg.sv
// fir_decim_avg
//   Downstream stage of the 5-tap FIR datapath. Averages each non-overlapping
//   block of 2^LOG2_DECIM accepted samples (accumulate-and-dump) and buffers
//   the decimated values in a small circular FIFO drained via valid/ready.
//
// Parameters
//   LOG2_DECIM  log2 of decimation factor (0..4); 0 = pass-through
//   FIFO_DEPTH  output FIFO entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   in_valid    in_data carries a sample this cycle (always consumed)
//   in_data     signed 8-bit sample
//   out_valid   FIFO non-empty, out_data valid
//   out_ready   consumer accepts out_data this cycle
//   out_data    signed decimated average at the FIFO head (registered)
//   fifo_count  current FIFO occupancy
//   overflow    sticky flag: a decimated value was dropped on a full FIFO
module fir_decim_avg #(
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = 8 + LOG2_DECIM;
  // A zero-width phase counter is not legal, so pass-through keeps a single
  // bit that never leaves 0 (first and last phase coincide).
  localparam int PW   = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CW   = PTRW + 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << LOG2_DECIM) - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [PW-1:0]        phase_q, phase_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [7:0]           mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;

  logic signed [7:0]    sample_s;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic [7:0]           avg;
  logic                 dump;
  logic                 pop;
  logic                 full;
  logic                 push_ok;

  // Accumulate-and-dump datapath. The block sum is formed combinationally so
  // the average can be pushed on the same edge that accepts the last sample.
  always_comb begin
    sample_s   = in_data;
    sample_ext = sample_s;
    sum        = (phase_q == '0) ? sample_ext : acc_q + sample_ext;
    shifted    = sum >>> LOG2_DECIM;
    avg        = shifted[7:0];
    dump       = in_valid && (phase_q == LAST_PHASE);

    phase_d = phase_q;
    acc_d   = acc_q;
    if (in_valid) begin
      acc_d   = sum;
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
    end
  end

  // FIFO control. A pop frees a slot in the same cycle, so a full FIFO still
  // accepts a dump when the consumer is draining.
  always_comb begin
    full    = (count_q == FULL_COUNT);
    pop     = (count_q != '0) && out_ready;
    push_ok = dump && (!full || pop);

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = avg;
    end

    rd_ptr_d = pop     ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTRW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q || (dump && full && !pop);

    // Registered head: when the slot being written becomes the new head
    // (empty FIFO, or last entry popped), forward the fresh average.
    out_data_d = 8'd0;
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = avg;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      acc_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= 8'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_avg.sv
// tb_fir_decim_avg
//   Scoreboard bench for fir_decim_avg. The stimulus process keeps a
//   block-level reference model (sample lists, floor division, an occupancy
//   count) and pushes every expected average into a queue; a separate monitor
//   pops and compares whenever the DUT hands a value to the consumer.
module tb_fir_decim_avg;

  localparam int LOG2_DECIM = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DECIM      = 1 << LOG2_DECIM;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int exp_q[$];
  int blk[$];
  int m_count = 0;
  bit m_ovf = 1'b0;

  fir_decim_avg #(
    .LOG2_DECIM(LOG2_DECIM),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Mathematical floor of s / DECIM
  function automatic int floorDiv(input int s);
    if (s >= 0) return s / DECIM;
    return -((-s + DECIM - 1) / DECIM);
  endfunction

  task automatic compare(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: inputs change just after the rising edge, so at the falling
  // edge out_valid && out_ready means a pop is committed for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compare("pop_unexpected", 1, 0);
        end else begin
          compare("pop_data", int'($signed(out_data)), exp_q.pop_front());
        end
      end
    end
  end

  // Compare the visible status against the model after each edge
  task automatic checkOutput();
    compare("out_valid", int'(out_valid), (m_count != 0) ? 1 : 0);
    compare("fifo_count", int'(fifo_count), m_count);
    compare("overflow", int'(overflow), int'(m_ovf));
    if (m_count != 0 && exp_q.size() != 0) begin
      compare("head_data", int'($signed(out_data)), exp_q[0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model for the coming edge, then
  // check the DUT once that edge has settled.
  task automatic applyStimulus(input bit v, input int d, input bit r);
    bit pop;
    int old_count;
    int s;
    in_valid  = v;
    in_data   = d[7:0];
    out_ready = r;
    old_count = m_count;
    pop = r && (old_count > 0);
    if (pop) m_count--;
    if (v) begin
      blk.push_back(int'($signed(d[7:0])));
      if (blk.size() == DECIM) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        blk.delete();
        if (old_count < FIFO_DEPTH || pop) begin
          exp_q.push_back(floorDiv(s));
          m_count++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd55;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    blk.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    compare("reset_out_data", int'(out_data), 0);
    checkOutput();
  endtask

  task automatic feedBlock(input int a, input int b, input int c, input int e, input bit r);
    applyStimulus(1'b1, a, r);
    applyStimulus(1'b1, b, r);
    applyStimulus(1'b1, c, r);
    applyStimulus(1'b1, e, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, r);
  endtask

  initial begin
    $display("[TB] start LOG2_DECIM=%0d FIFO_DEPTH=%0d", LOG2_DECIM, FIFO_DEPTH);
    @(posedge clk);
    #1;
    doReset();

    // Basic average
    feedBlock(4, 8, 12, 16, 1'b1);
    idle(3, 1'b1);

    // Signed rounding and extremes
    feedBlock(-1, -2, -3, -4, 1'b1);
    feedBlock(127, 127, 127, 127, 1'b1);
    feedBlock(-128, -128, -128, -128, 1'b1);
    feedBlock(127, 127, -128, -128, 1'b1);
    idle(3, 1'b1);

    // Valid gaps: phase holds while in_valid is low
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 4 * k, 1'b1);
      if (k < 4) idle(3, 1'b1);
    end
    idle(3, 1'b1);

    // Back-pressure and overflow: fifth average is lost
    for (int k = 1; k <= 5; k++) feedBlock(k, k, k, k, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Full FIFO with a pop on the same cycle as the dump
    doReset();
    for (int k = 1; k <= 4; k++) feedBlock(k, k, k, k, 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    applyStimulus(1'b1, 9, 1'b1);
    idle(6, 1'b1);

    // Reset mid-block discards the partial accumulation
    applyStimulus(1'b1, 100, 1'b1);
    applyStimulus(1'b1, 100, 1'b1);
    doReset();
    feedBlock(20, 20, 20, 20, 1'b1);
    idle(3, 1'b1);

    // Reset with three entries queued
    for (int k = 1; k <= 3; k++) feedBlock(-k, -k, -k, -k, 1'b0);
    doReset();
    idle(2, 1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 255)) - 128,
                      $urandom_range(0, 1) == 1);
      end
    end
    idle(2 * FIFO_DEPTH, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
